// File: rtl/read_sequencer.sv
// read_sequencer: issues a run of strided read bursts to a read engine and
// collects per-run statistics (beat count, XOR of data, cycles, errors).
module read_sequencer #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_num_bursts,
  input  logic [LEN_WIDTH-1:0]  cfg_burst_len,
  output logic                  start,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [LEN_WIDTH-1:0]  burst,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_ready,
  input  logic                  read_end,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  bursts_done,
  output logic [DATA_WIDTH-1:0] data_xor,
  output logic [CNT_WIDTH-1:0]  total_cycles
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  local_cnt, local_nxt, bursts_inc, beats_want;
  logic [TW-1:0]         wait_cnt;
  logic                  end_q, end_edge, timeout_hit;
  logic                  start_d, done_d, busy_d;

  // Only a 0->1 transition of read_end closes a burst; a held level is ignored.
  assign end_edge    = read_end && !end_q;
  // A beat arriving together with the end edge is included in the check.
  assign local_nxt   = local_cnt + CNT_WIDTH'(read_ready);
  assign beats_want  = CNT_WIDTH'(burst) + CNT_WIDTH'(1);
  assign bursts_inc  = bursts_done + CNT_WIDTH'(1);
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cfg_start) state_n = (cfg_num_bursts == '0) ? FINISH : ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (end_edge)         state_n = NEXT;
               else if (timeout_hit) state_n = FINISH;
      NEXT:    state_n = (bursts_inc == num_q) ? FINISH : ISSUE;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode; these feed registers so start coincides with ISSUE and
  // done follows FINISH by one cycle, together with busy falling.
  always_comb begin
    start_d = (state_n == ISSUE);
    done_d  = (state == FINISH);
    busy_d  = (state_n != IDLE);
  end

  // Registered outputs, run configuration and statistics
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start        <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      read_addr    <= '0;
      burst        <= '0;
      beat_count   <= '0;
      bursts_done  <= '0;
      data_xor     <= '0;
      total_cycles <= '0;
      stride_q     <= '0;
      num_q        <= '0;
      local_cnt    <= '0;
      wait_cnt     <= '0;
      end_q        <= 1'b0;
    end else begin
      end_q <= read_end;
      start <= start_d;
      done  <= done_d;
      busy  <= busy_d;
      if (busy && total_cycles != '1) total_cycles <= total_cycles + CNT_WIDTH'(1);
      case (state)
        IDLE: if (cfg_start) begin
          stride_q     <= cfg_stride;
          num_q        <= cfg_num_bursts;
          beat_count   <= '0;
          bursts_done  <= '0;
          data_xor     <= '0;
          total_cycles <= '0;
          error        <= 1'b0;
          if (cfg_num_bursts != '0) begin
            read_addr <= cfg_base_addr;
            burst     <= cfg_burst_len;
          end
        end
        ISSUE: begin
          local_cnt <= '0;
          wait_cnt  <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + TW'(1);
          if (read_ready) begin
            beat_count <= beat_count + CNT_WIDTH'(1);
            data_xor   <= data_xor ^ read_data;
            local_cnt  <= local_nxt;
          end
          if (end_edge) begin
            if (local_nxt != beats_want) error <= 1'b1;
          end else if (timeout_hit) begin
            error <= 1'b1;
          end
        end
        NEXT: begin
          bursts_done <= bursts_inc;
          if (state_n == ISSUE) read_addr <= read_addr + stride_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_read_sequencer.sv
// Bench for read_sequencer: a behavioural read engine answers each start
// pulse; expected burst addresses are queued when a run is configured and
// compared against the observed start pulses; run statistics come from a
// table of vectors plus a hand-written mid-run reset sequence.
module tb_read_sequencer;
  localparam int AW = 33, DW = 64, LW = 8, CW = 32, TO = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cfg_start;
  logic [AW-1:0] cfg_base_addr, cfg_stride;
  logic [CW-1:0] cfg_num_bursts;
  logic [LW-1:0] cfg_burst_len;
  logic          start;
  logic [AW-1:0] read_addr;
  logic [LW-1:0] burst;
  logic [DW-1:0] read_data;
  logic          read_ready, read_end;
  logic          busy, done, error;
  logic [CW-1:0] beat_count, bursts_done, total_cycles;
  logic [DW-1:0] data_xor;

  read_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                   .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .cfg_start(cfg_start),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride),
    .cfg_num_bursts(cfg_num_bursts), .cfg_burst_len(cfg_burst_len),
    .start(start), .read_addr(read_addr), .burst(burst),
    .read_data(read_data), .read_ready(read_ready), .read_end(read_end),
    .busy(busy), .done(done), .error(error), .beat_count(beat_count),
    .bursts_done(bursts_done), .data_xor(data_xor), .total_cycles(total_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            cyc;
  } obs_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [CW-1:0] num;
    logic [LW-1:0] len;
    int            beats;   // beats returned per burst
    int            hold;    // read_end high cycles
    bit            ewl;     // read_end asserted with the last beat
    bit            noend;   // engine never signals read_end
    bit            e_err;
    int            e_bursts;
    int            e_beats;
  } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cyc = 0;
  obs_t          obs_q[$];
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] beat_q[$];
  int eng_beats = 0, eng_hold = 1;
  bit eng_ewl = 1'b0, eng_noend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record start pulses, done pulses and busy cycles
  always @(negedge clk) begin
    if (start) obs_q.push_back('{read_addr, burst, cyc});
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  // Read engine model
  initial begin
    read_ready = 1'b0; read_end = 1'b0; read_data = '0;
    forever begin
      @(negedge clk);
      if (start && resetn) begin
        for (int b = 0; b < eng_beats; b++) begin
          @(posedge clk); #1;
          read_ready = 1'b1;
          read_data  = {$urandom, $urandom};
          beat_q.push_back(read_data);
          read_end   = (eng_ewl && !eng_noend && b == eng_beats - 1);
        end
        if (!eng_noend) begin
          if (!read_end) begin
            @(posedge clk); #1; read_ready = 1'b0; read_end = 1'b1;
          end
          for (int h = 1; h < eng_hold; h++) begin
            @(posedge clk); #1; read_ready = 1'b0; read_end = 1'b1;
          end
        end
        @(posedge clk); #1; read_ready = 1'b0; read_end = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " start"}, 64'(start), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " error"}, 64'(error), 64'd0);
    chk({tag, " read_addr"}, 64'(read_addr), 64'd0);
    chk({tag, " burst"}, 64'(burst), 64'd0);
    chk({tag, " beat_count"}, 64'(beat_count), 64'd0);
    chk({tag, " bursts_done"}, 64'(bursts_done), 64'd0);
    chk({tag, " data_xor"}, 64'(data_xor), 64'd0);
    chk({tag, " total_cycles"}, 64'(total_cycles), 64'd0);
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_base_addr = v.base; cfg_stride = v.stride;
    cfg_num_bursts = v.num; cfg_burst_len = v.len;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [AW-1:0] a;
    logic [DW-1:0] x;
    int n_st, d0, b0, cfgc, last_st;
    obs_t o;
    string tg;
    tg = $sformatf("v%0d", idx);
    eng_beats = v.beats; eng_hold = v.hold; eng_ewl = v.ewl; eng_noend = v.noend;
    n_st = v.noend ? ((v.num != 0) ? 1 : 0) : int'(v.num);
    a = v.base;
    for (int i = 0; i < n_st; i++) begin
      exp_q.push_back(a);
      a = a + v.stride;
    end
    d0 = done_cnt; b0 = busy_cyc; last_st = 0;
    @(posedge clk); #1;
    drive_cfg(v); cfg_start = 1'b1; cfgc = cyc;
    @(posedge clk); #1; cfg_start = 1'b0;
    if (v.num != 0) begin
      // a second request while busy must be ignored
      @(posedge clk); #1;
      cfg_base_addr = 33'h0ABC0; cfg_stride = 33'h10;
      cfg_num_bursts = 32'd7; cfg_burst_len = 8'd2; cfg_start = 1'b1;
      @(posedge clk); #1; cfg_start = 1'b0;
    end
    for (int t = 0; t < 600 && done_cnt == d0; t++) @(negedge clk);
    if (done_cnt == d0) chk({tg, " done_seen"}, 64'd0, 64'd1);
    repeat (4) @(negedge clk);
    chk({tg, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tg, " busy_after"}, 64'(busy), 64'd0);
    chk({tg, " error"}, 64'(error), 64'(v.e_err));
    chk({tg, " bursts_done"}, 64'(bursts_done), 64'(v.e_bursts));
    chk({tg, " beat_count"}, 64'(beat_count), 64'(v.e_beats));
    chk({tg, " total_cycles"}, 64'(total_cycles), 64'(busy_cyc - b0));
    x = '0;
    while (beat_q.size() > 0) x ^= beat_q.pop_front();
    chk({tg, " data_xor"}, 64'(data_xor), 64'(x));
    chk({tg, " start_pulses"}, 64'(obs_q.size()), 64'(n_st));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({tg, " read_addr"}, 64'(o.addr), 64'(exp_q.pop_front()));
      chk({tg, " burst"}, 64'(o.len), 64'(v.len));
      last_st = o.cyc;
    end
    obs_q.delete(); exp_q.delete();
    if (v.num == 0) chk({tg, " done_latency"}, 64'(done_cyc - cfgc), 64'd2);
    if (v.noend && v.num != 0) chk({tg, " timeout_latency"}, 64'(done_cyc - last_st), 64'(TO + 2));
  endtask

  vec_t vecs[8];
  vec_t rv;
  int d0;

  initial begin
    vecs[0] = '{33'h1000, 33'h400, 32'd3, 8'd7, 8, 1, 1'b0, 1'b0, 1'b0, 3, 24};
    vecs[1] = '{33'h5000, 33'h100, 32'd0, 8'd7, 8, 1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[2] = '{33'h2000, 33'h80,  32'd2, 8'd3, 3, 1, 1'b0, 1'b0, 1'b1, 2, 6};
    vecs[3] = '{33'h3000, 33'h40,  32'd2, 8'd1, 2, 2, 1'b0, 1'b0, 1'b0, 2, 4};
    vecs[4] = '{33'h4000, 33'h40,  32'd2, 8'd3, 4, 1, 1'b1, 1'b0, 1'b0, 2, 8};
    vecs[5] = '{33'h6000, 33'h40,  32'd2, 8'd3, 0, 1, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[6] = '{33'h1_FFFF_FFE0, 33'h20, 32'd2, 8'd0, 1, 1, 1'b0, 1'b0, 1'b0, 2, 2};
    vecs[7] = '{33'h7000, 33'h40,  32'd1, 8'd1, 3, 2, 1'b1, 1'b0, 1'b1, 1, 3};

    resetn = 1'b0; cfg_start = 1'b0;
    cfg_base_addr = '0; cfg_stride = '0; cfg_num_bursts = '0; cfg_burst_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1; resetn = 1'b1;

    // Mid-WAIT reset: outputs clear next cycle, in-flight beats are dropped
    rv = '{33'h2000, 33'h400, 32'd4, 8'd7, 8, 1, 1'b0, 1'b0, 1'b0, 0, 0};
    eng_beats = 8; eng_hold = 1; eng_ewl = 1'b0; eng_noend = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1; drive_cfg(rv); cfg_start = 1'b1;
    @(posedge clk); #1; cfg_start = 1'b0;
    for (int t = 0; t < 50 && obs_q.size() == 0; t++) @(negedge clk);
    chk("rst first_start", 64'(obs_q.size()), 64'd1);
    repeat (3) @(posedge clk);
    #1; resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1; resetn = 1'b1;
    repeat (14) @(negedge clk);
    chk("postrst busy", 64'(busy), 64'd0);
    chk("postrst beat_count", 64'(beat_count), 64'd0);
    chk("postrst start_pulses", 64'(obs_q.size()), 64'd1);
    chk("postrst done_pulses", 64'(done_cnt - d0), 64'd0);
    obs_q.delete(); beat_q.delete(); exp_q.delete();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
